capture_engine: RTL and testbench

//  Parametrised successor to the single-shot sampler: trigger-qualified capture of a

---
 rtl/capture_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_capture_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_engine.sv
`default_nettype none
// ============================================================================
// Module      : capture_engine
// Description : Trigger-qualified capture of an ADC sample stream into a
//               circular sample RAM. The engine drives the RAM write port.
//               It supports a programmable trigger level and edge direction,
//               a programmable post-trigger length, and force, auto and abort
//               controls. It reports the trigger address and the address of
//               the oldest sample for readout logic.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_engine #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic              auto_en,
  input  logic              trig_rising,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_we,
  output logic              busy,
  output logic              done,
  output logic              triggered,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] first_addr
);

  // The timeout counter saturates at AUTO_TIMEOUT-1. A valid sample seen at
  // that count is the AUTO_TIMEOUT-th sample, so it becomes the trigger.
  localparam int                c_TO_W     = (AUTO_TIMEOUT < 2) ? 1 : $clog2(AUTO_TIMEOUT);
  localparam logic [c_TO_W-1:0] c_TO_MAX   = c_TO_W'(AUTO_TIMEOUT - 1);
  localparam logic [c_TO_W-1:0] c_TO_ONE   = c_TO_W'(1);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_ADDR_TWO = ADDR_W'(2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE_FILL  = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST_TRIG = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_cnt;
  logic [c_TO_W-1:0]   r_timeout;
  logic [ADDR_W-1:0]   r_p;
  logic [DATA_W-1:0]   r_level;
  logic                r_rising;
  logic                r_above_prev;
  logic                r_force_pend;
  logic                r_m_we;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic                r_done;
  logic                r_triggered;
  logic [ADDR_W-1:0]   r_trig_addr;
  logic [ADDR_W-1:0]   r_first_addr;

  logic                w_busy;
  logic                w_above;
  logic                w_edge;
  logic                w_auto_hit;
  logic                w_trig;
  logic                w_write;
  logic [ADDR_W-1:0]   w_ptr_inc;
  logic [ADDR_W-1:0]   w_p_arm;
  logic [ADDR_W-1:0]   w_pre_len;
  logic                w_pre_last;
  logic                w_post_last;

  assign w_busy = (r_state == S_PRE_FILL) || (r_state == S_WAIT_TRIG) ||
                  (r_state == S_POST_TRIG);

  // The history bit records whether the last sample was at or above the level.
  // A rising trigger is a low-to-high crossing; a falling trigger is high-to-low.
  assign w_above    = (data_in >= r_level);
  assign w_edge     = r_rising ? (w_above & ~r_above_prev) : (~w_above & r_above_prev);
  assign w_auto_hit = auto_en && (r_timeout == c_TO_MAX);
  assign w_trig     = (r_state == S_WAIT_TRIG) && data_valid &&
                      (w_edge || force_trig || r_force_pend || w_auto_hit);
  assign w_write    = w_busy && data_valid && !abort;

  assign w_ptr_inc   = r_wr_ptr + c_ADDR_ONE;
  assign w_p_arm     = (post_count == '0) ? c_ADDR_ONE : post_count;
  // With P >= 1, the value DEPTH - P fits in ADDR_W bits. Unsigned wrap yields it.
  assign w_pre_len   = '0 - r_p;
  assign w_pre_last  = (r_cnt == (w_pre_len - c_ADDR_ONE));
  assign w_post_last = (r_cnt == (r_p - c_ADDR_TWO));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; abort overrides every other input
  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (arm) w_state_next = S_PRE_FILL;
        S_PRE_FILL:     if (data_valid && w_pre_last) w_state_next = S_WAIT_TRIG;
        S_WAIT_TRIG:    if (w_trig) w_state_next = (r_p == c_ADDR_ONE) ? S_DONE : S_POST_TRIG;
        S_POST_TRIG:    if (data_valid && w_post_last) w_state_next = S_DONE;
        default:        w_state_next = S_IDLE;
      endcase
    end
  end

  // Write port, capture settings, counters and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_timeout    <= '0;
      r_p          <= '0;
      r_level      <= '0;
      r_rising     <= 1'b0;
      r_above_prev <= 1'b0;
      r_force_pend <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_done       <= 1'b0;
      r_triggered  <= 1'b0;
      r_trig_addr  <= '0;
      r_first_addr <= '0;
    end else begin
      r_m_we <= w_write;
      if (w_write) begin
        r_m_addr  <= r_wr_ptr;
        r_m_wdata <= data_in;
        r_wr_ptr  <= w_ptr_inc;
      end

      if (abort) begin
        r_done       <= 1'b0;
        r_triggered  <= 1'b0;
        r_force_pend <= 1'b0;
      end else if (arm && !w_busy) begin
        r_p          <= w_p_arm;
        r_level      <= trig_level;
        r_rising     <= trig_rising;
        r_above_prev <= trig_rising;
        r_wr_ptr     <= '0;
        r_cnt        <= '0;
        r_timeout    <= '0;
        r_force_pend <= 1'b0;
        r_done       <= 1'b0;
        r_triggered  <= 1'b0;
      end else begin
        if (w_busy && data_valid) begin
          r_above_prev <= w_above;
        end
        case (r_state)
          S_PRE_FILL: begin
            if (data_valid) begin
              r_cnt <= w_pre_last ? '0 : (r_cnt + c_ADDR_ONE);
              if (w_pre_last) r_timeout <= '0;
            end
          end
          S_WAIT_TRIG: begin
            if (w_trig) begin
              r_trig_addr  <= r_wr_ptr;
              r_triggered  <= 1'b1;
              r_force_pend <= 1'b0;
              r_cnt        <= '0;
              if (r_p == c_ADDR_ONE) begin
                r_done       <= 1'b1;
                r_first_addr <= w_ptr_inc;
              end
            end else begin
              // A force that arrives without a valid sample applies to the next valid sample
              if (force_trig) r_force_pend <= 1'b1;
              if (data_valid && (r_timeout != c_TO_MAX)) r_timeout <= r_timeout + c_TO_ONE;
            end
          end
          S_POST_TRIG: begin
            if (data_valid) begin
              r_cnt <= r_cnt + c_ADDR_ONE;
              if (w_post_last) begin
                r_done       <= 1'b1;
                r_first_addr <= w_ptr_inc;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign m_addr     = r_m_addr;
  assign m_wdata    = r_m_wdata;
  assign m_we       = r_m_we;
  assign busy       = w_busy;
  assign done       = r_done;
  assign triggered  = r_triggered;
  assign trig_addr  = r_trig_addr;
  assign first_addr = r_first_addr;

endmodule
`default_nettype wire

// File: tb/tb_capture_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_capture_engine
// Description : Directed-vector bench for capture_engine (DEPTH=16, AUTO=5).
//               Expected writes and completion addresses go into queues. A
//               separate monitor pops and compares those queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_engine;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          force_trig = 1'b0;
  logic          auto_en = 1'b0;
  logic          trig_rising = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic [AW-1:0] post_count = '0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic          busy;
  logic          done;
  logic          triggered;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] first_addr;

  int checks = 0;
  int errors = 0;

  logic [AW+DW-1:0] exp_wr_q[$];
  logic [2*AW-1:0]  exp_done_q[$];
  logic [AW-1:0]    exp_ptr = '0;
  int               wr_left = 0;
  logic             done_d = 1'b0;

  capture_engine #(
    .DATA_W(DW), .DEPTH(16), .AUTO_TIMEOUT(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .force_trig(force_trig),
    .auto_en(auto_en), .trig_rising(trig_rising), .trig_level(trig_level),
    .post_count(post_count), .data_in(data_in), .data_valid(data_valid),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .busy(busy), .done(done),
    .triggered(triggered), .trig_addr(trig_addr), .first_addr(first_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every RAM write and every completion against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_we) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h required none", m_addr, m_wdata);
        end else begin
          chk("write_addr_data", 32'({m_addr, m_wdata}), 32'(exp_wr_q.pop_front()));
        end
      end
      if (done && !done_d) begin
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          chk("trig_addr", 32'(trig_addr), 32'(exp_done_q[0][7:4]));
          chk("first_addr", 32'(first_addr), 32'(exp_done_q[0][3:0]));
          chk("triggered_at_done", 32'(triggered), 32'd1);
          exp_done_q.delete(0);
        end
      end
      done_d <= done;
    end
  end

  // One clock of stimulus. A valid sample inside the expected capture window queues a write.
  task automatic cyc(input logic [DW-1:0] d, input logic v, input logic f = 1'b0);
    data_in = d;
    data_valid = v;
    force_trig = f;
    if (v && wr_left > 0) begin
      exp_wr_q.push_back({exp_ptr, d});
      exp_ptr = exp_ptr + 4'd1;
      wr_left--;
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
    force_trig = 1'b0;
  endtask

  // Arm a capture. The test supplies the write count and completion addresses,
  // both computed by hand. The settings are then scrambled to prove they were latched.
  task automatic start(input logic [AW-1:0] pc, input logic [DW-1:0] lvl, input logic rising,
                       input logic aen, input int nwr, input logic [AW-1:0] etrig,
                       input logic [AW-1:0] efirst, input logic expect_done);
    post_count = pc;
    trig_level = lvl;
    trig_rising = rising;
    auto_en = aen;
    data_valid = 1'b0;
    arm = 1'b1;
    wr_left = nwr;
    exp_ptr = '0;
    if (expect_done) exp_done_q.push_back({etrig, efirst});
    @(posedge clk); #1;
    arm = 1'b0;
    post_count = ~pc;
    trig_level = ~lvl;
    trig_rising = ~rising;
    chk("busy_after_arm", 32'(busy), 32'd1);
    chk("done_after_arm", 32'(done), 32'd0);
    chk("triggered_after_arm", 32'(triggered), 32'd0);
  endtask

  task automatic check_done_state();
    chk("done_level", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("triggered_level", 32'(triggered), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_we", 32'(m_we), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_triggered", 32'(triggered), 32'd0);
    chk("reset_trig_addr", 32'(trig_addr), 32'd0);
    chk("reset_first_addr", 32'(first_addr), 32'd0);
    chk("reset_m_addr_wdata", 32'({m_addr, m_wdata}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // Ramp, P=8, rising 0x80: 8 pre samples, trigger on 0x80 at addr 8, 7 post samples
    start(4'd8, 8'h80, 1'b1, 1'b0, 16, 4'd8, 4'd0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(8'(i * 16), 1'b1);
    cyc(8'h55, 1'b1);
    cyc(8'h66, 1'b1);
    check_done_state();

    // P=12 (4 pre). The edge during pre-fill is ignored. The same edge in WAIT triggers at addr 5.
    start(4'd12, 8'h80, 1'b1, 1'b0, 17, 4'd5, 4'd1, 1'b1);
    cyc(8'h70, 1'b1);
    cyc(8'h90, 1'b1);
    chk("no_trig_in_prefill", 32'(triggered), 32'd0);
    cyc(8'h70, 1'b1);
    cyc(8'h70, 1'b1);
    cyc(8'h70, 1'b1);
    cyc(8'h90, 1'b1);
    chk("edge_trig_in_wait", 32'(triggered), 32'd1);
    chk("not_done_after_trig", 32'(done), 32'd0);
    for (int i = 0; i < 11; i++) cyc(8'(8'hA0 + i), 1'b1);
    cyc(8'h10, 1'b1);
    check_done_state();

    // Falling, level 0x40, P=4 (12 pre). 0x30->0x50 is not a trigger; 0x50->0x30 triggers at 13.
    start(4'd4, 8'h40, 1'b0, 1'b0, 17, 4'd13, 4'd1, 1'b1);
    for (int i = 0; i < 11; i++) cyc(8'h50, 1'b1);
    cyc(8'h30, 1'b1);
    cyc(8'h50, 1'b1);
    chk("falling_no_trig_upward", 32'(triggered), 32'd0);
    cyc(8'h30, 1'b1);
    chk("falling_trig", 32'(triggered), 32'd1);
    cyc(8'h11, 1'b1);
    cyc(8'h22, 1'b1);
    cyc(8'h33, 1'b1);
    check_done_state();

    // Auto trigger on the 5th valid WAIT sample (addr 12). Invalid cycles do not count.
    start(4'd8, 8'h80, 1'b1, 1'b1, 20, 4'd12, 4'd4, 1'b1);
    auto_en = 1'b1;
    for (int i = 0; i < 8; i++) cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b0);
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b0);
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);
    chk("auto_not_yet", 32'(triggered), 32'd0);
    cyc(8'h00, 1'b1);
    chk("auto_trig", 32'(triggered), 32'd1);
    for (int i = 0; i < 7; i++) cyc(8'h00, 1'b1);
    check_done_state();
    auto_en = 1'b0;

    // Abort during POST_TRIG, after the trigger and 2 post samples
    start(4'd8, 8'h80, 1'b1, 1'b0, 11, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 11; i++) cyc(8'(i * 16), 1'b1);
    chk("triggered_before_abort", 32'(triggered), 32'd1);
    abort = 1'b1;
    data_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_triggered", 32'(triggered), 32'd0);
    chk("abort_m_we", 32'(m_we), 32'd0);
    cyc(8'h80, 1'b1);
    cyc(8'h90, 1'b1);
    chk("idle_no_write", 32'(m_we), 32'd0);

    // Re-arm with post_count=0 (P=1, 15 pre) and 50% valid. Arm is ignored mid-capture.
    // A force on an invalid cycle triggers on the next valid sample at addr 15. first_addr wraps to 0.
    start(4'd0, 8'hFF, 1'b1, 1'b0, 16, 4'd15, 4'd0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      cyc(8'(i * 7 + 1), 1'b1);
      if (i == 5) arm = 1'b1;
      cyc(8'h00, 1'b0);
      arm = 1'b0;
    end
    cyc(8'h00, 1'b0, 1'b1);
    chk("force_pending", 32'(triggered), 32'd0);
    cyc(8'hAB, 1'b1);
    check_done_state();

    repeat (3) @(posedge clk);
    #1;
    chk("write_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    chk("done_queue_drained", 32'(exp_done_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
